// File: rtl/c1541_sector_server.sv
// c1541_sector_server
// Serves single-sector (512-byte) requests from the drive track buffer out of
// a byte-wide image memory, so the drive can run from a preloaded image with
// no HPS involvement. The design sits entirely in the sd_clk domain.
//
// Ports:
//   sd_clk, reset          clock and synchronous active-high reset
//   sd_lba, sd_rd, sd_wr   sector request (levels). sd_lba is latched on accept.
//   sd_ack                 high while a transfer is in progress
//   sd_buff_addr/dout/wr   byte index, read data and write strobe to the track buffer
//   sd_buff_din            write data from the track buffer (1-cycle read latency)
//   wp                     write protect: writes walk the sector but touch no memory
//   mem_addr/rd/wr/wdata   image memory request, held until mem_ack
//   mem_rdata, mem_ack     memory read data and one-cycle completion pulse
//   err                    sticky: last request hit out-of-range, timeout or wp
//   busy                   state machine not idle
module c1541_sector_server #(
  parameter int ADDR_W  = 20,
  parameter int TIMEOUT = 1023
) (
  input  logic              sd_clk,
  input  logic              reset,
  input  logic [31:0]       sd_lba,
  input  logic              sd_rd,
  input  logic              sd_wr,
  output logic              sd_ack,
  output logic [8:0]        sd_buff_addr,
  output logic [7:0]        sd_buff_dout,
  input  logic [7:0]        sd_buff_din,
  output logic              sd_buff_wr,
  input  logic              wp,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  output logic              err,
  output logic              busy
);

  localparam int         SEC_W  = ADDR_W - 9;
  localparam logic [9:0] TO_LIM = 10'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_PUT, WR_ADDR, WR_WAIT, WR_CAP, WR_MEM, FINISH
  } state_t;

  // Any set bit above the sector field means the sector lies outside the image.
  function automatic logic lba_out_of_range(input logic [31:0] lba);
    return ((lba >> SEC_W) != 32'd0);
  endfunction

  state_t           state_r, state_s;
  logic             armed_r, armed_s;
  logic [SEC_W-1:0] lba_r, lba_s;
  logic             oor_r, oor_s;
  logic [8:0]       n_r, n_s;
  logic [9:0]       to_cnt_r, to_cnt_s;
  logic             ack_r, ack_s;
  logic [7:0]       dout_r, dout_s;
  logic             buff_wr_r, buff_wr_s;
  logic             mem_rd_r, mem_rd_s;
  logic             mem_wr_r, mem_wr_s;
  logic [7:0]       wdata_r, wdata_s;
  logic             err_r, err_s;
  logic             busy_r, busy_s;
  logic             last_s;

  // Next-state and next-output logic; every output is the image of a register.
  always_comb begin
    state_s   = state_r;
    lba_s     = lba_r;
    oor_s     = oor_r;
    n_s       = n_r;
    to_cnt_s  = to_cnt_r;
    ack_s     = ack_r;
    dout_s    = dout_r;
    buff_wr_s = 1'b0;
    mem_rd_s  = mem_rd_r;
    mem_wr_s  = mem_wr_r;
    wdata_s   = wdata_r;
    err_s     = err_r;
    last_s    = (n_r == 9'd511);

    // Re-arm whenever the requester shows both request levels low.
    if (!sd_rd && !sd_wr) begin
      armed_s = 1'b1;
    end else begin
      armed_s = armed_r;
    end

    case (state_r)
      IDLE: begin
        if (armed_r && (sd_rd || sd_wr)) begin
          armed_s  = 1'b0;
          lba_s    = sd_lba[SEC_W-1:0];
          oor_s    = lba_out_of_range(sd_lba);
          err_s    = 1'b0;
          n_s      = 9'd0;
          to_cnt_s = 10'd0;
          ack_s    = 1'b1;
          // A write wins when both levels are high; the read waits for re-arm.
          if (sd_wr) begin
            state_s = WR_ADDR;
          end else begin
            state_s  = RD_REQ;
            mem_rd_s = !lba_out_of_range(sd_lba);
          end
        end else begin
          state_s = IDLE;
        end
      end
      RD_REQ: begin
        if (oor_r) begin
          dout_s    = 8'h00;
          err_s     = 1'b1;
          buff_wr_s = 1'b1;
          state_s   = RD_PUT;
        end else if (mem_ack) begin
          dout_s    = mem_rdata;
          mem_rd_s  = 1'b0;
          buff_wr_s = 1'b1;
          state_s   = RD_PUT;
        end else if (to_cnt_r == TO_LIM) begin
          dout_s    = 8'hFF;
          err_s     = 1'b1;
          mem_rd_s  = 1'b0;
          buff_wr_s = 1'b1;
          state_s   = RD_PUT;
        end else begin
          to_cnt_s = to_cnt_r + 10'd1;
        end
      end
      RD_PUT: begin
        // n is 9 bits, so the increment after byte 511 returns it to 0.
        n_s = n_r + 9'd1;
        if (last_s) begin
          ack_s   = 1'b0;
          state_s = FINISH;
        end else begin
          mem_rd_s = !oor_r;
          to_cnt_s = 10'd0;
          state_s  = RD_REQ;
        end
      end
      WR_ADDR: begin
        state_s = WR_WAIT;
      end
      WR_WAIT: begin
        // Address held for the requester's registered buffer read.
        state_s = WR_CAP;
      end
      WR_CAP: begin
        wdata_s = sd_buff_din;
        if (wp || oor_r) begin
          err_s = 1'b1;
          n_s   = n_r + 9'd1;
          if (last_s) begin
            ack_s   = 1'b0;
            state_s = FINISH;
          end else begin
            state_s = WR_ADDR;
          end
        end else begin
          mem_wr_s = 1'b1;
          to_cnt_s = 10'd0;
          state_s  = WR_MEM;
        end
      end
      WR_MEM: begin
        if (mem_ack || (to_cnt_r == TO_LIM)) begin
          mem_wr_s = 1'b0;
          if (!mem_ack) begin
            err_s = 1'b1;
          end else begin
            err_s = err_r;
          end
          n_s = n_r + 9'd1;
          if (last_s) begin
            ack_s   = 1'b0;
            state_s = FINISH;
          end else begin
            state_s = WR_ADDR;
          end
        end else begin
          to_cnt_s = to_cnt_r + 10'd1;
        end
      end
      FINISH: begin
        state_s = IDLE;
      end
      default: begin
        state_s  = IDLE;
        ack_s    = 1'b0;
        mem_rd_s = 1'b0;
        mem_wr_s = 1'b0;
      end
    endcase

    busy_s = (state_s != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge sd_clk) begin
    if (reset) begin
      state_r   <= IDLE;
      armed_r   <= 1'b1;
      lba_r     <= '0;
      oor_r     <= 1'b0;
      n_r       <= 9'd0;
      to_cnt_r  <= 10'd0;
      ack_r     <= 1'b0;
      dout_r    <= 8'h00;
      buff_wr_r <= 1'b0;
      mem_rd_r  <= 1'b0;
      mem_wr_r  <= 1'b0;
      wdata_r   <= 8'h00;
      err_r     <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      armed_r   <= armed_s;
      lba_r     <= lba_s;
      oor_r     <= oor_s;
      n_r       <= n_s;
      to_cnt_r  <= to_cnt_s;
      ack_r     <= ack_s;
      dout_r    <= dout_s;
      buff_wr_r <= buff_wr_s;
      mem_rd_r  <= mem_rd_s;
      mem_wr_r  <= mem_wr_s;
      wdata_r   <= wdata_s;
      err_r     <= err_s;
      busy_r    <= busy_s;
    end
  end

  assign sd_ack       = ack_r;
  assign sd_buff_addr = n_r;
  assign sd_buff_dout = dout_r;
  assign sd_buff_wr   = buff_wr_r;
  assign mem_addr     = {lba_r, n_r};
  assign mem_rd       = mem_rd_r;
  assign mem_wr       = mem_wr_r;
  assign mem_wdata    = wdata_r;
  assign err          = err_r;
  assign busy         = busy_r;

endmodule

// File: tb/tb_c1541_sector_server.sv
// Directed bench for c1541_sector_server: image memory model returning
// addr[7:0], track buffer model returning ~addr[7:0] one cycle late.
module tb_c1541_sector_server;

  localparam int ADDR_W = 20;

  logic              sd_clk;
  logic              reset;
  logic [31:0]       sd_lba;
  logic              sd_rd;
  logic              sd_wr;
  logic              sd_ack;
  logic [8:0]        sd_buff_addr;
  logic [7:0]        sd_buff_dout;
  logic [7:0]        sd_buff_din;
  logic              sd_buff_wr;
  logic              wp;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              mem_ack;
  logic              err;
  logic              busy;

  c1541_sector_server #(.ADDR_W(ADDR_W), .TIMEOUT(1023)) dut (
    .sd_clk(sd_clk), .reset(reset), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
    .sd_buff_din(sd_buff_din), .sd_buff_wr(sd_buff_wr), .wp(wp),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err), .busy(busy)
  );

  initial sd_clk = 1'b0;
  always #5 sd_clk = ~sd_clk;

  // Memory model: combinational ack, or one-cycle-late ack in lat_mode.
  logic lat_mode, nack_en, ack_q;
  always @(posedge sd_clk) ack_q <= lat_mode && (mem_rd || mem_wr) && !ack_q;
  assign mem_ack   = (nack_en && mem_rd && (mem_addr[8:0] == 9'd7)) ? 1'b0 :
                     lat_mode ? ack_q : (mem_rd | mem_wr);
  assign mem_rdata = mem_addr[7:0];

  // Track buffer model: registered read of ~addr.
  always @(posedge sd_clk) sd_buff_din <= ~sd_buff_addr[7:0];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor state, cleared before each transfer.
  logic [7:0] sdat [512];
  int s_cnt, s_order_err, mr_cnt, mr_err, mw_cnt, mw_err, bh_cnt;
  int ack_rise, ack_hi, walk_cnt, walk_bad, r7_hi, exp_base;
  logic ack_prev;
  logic [8:0] addr_prev;

  always @(negedge sd_clk) begin
    if (sd_buff_wr) begin
      if (int'(sd_buff_addr) != s_cnt) s_order_err++;
      sdat[sd_buff_addr] = sd_buff_dout;
      s_cnt++;
    end
    if (mem_rd && mem_ack) begin
      if (int'(mem_addr) != exp_base + s_cnt) mr_err++;
      mr_cnt++;
    end
    if (mem_rd && (mem_addr[8:0] == 9'd7)) r7_hi++;
    if (mem_wr && mem_ack) begin
      if ((int'(mem_addr) != exp_base + mw_cnt) || (mem_wdata !== 8'(~mw_cnt))) mw_err++;
      mw_cnt++;
    end
    if (mem_rd && mem_wr) bh_cnt++;
    if (sd_ack && !ack_prev) ack_rise++;
    if (sd_ack) ack_hi++;
    if (sd_ack && (sd_buff_addr != addr_prev)) begin
      if (sd_buff_addr != addr_prev + 9'd1) walk_bad++;
      walk_cnt++;
    end
    ack_prev  = sd_ack;
    addr_prev = sd_buff_addr;
  end

  task automatic clear_mon(input logic [31:0] lba);
    logic [10:0] sec;
    sec = lba[10:0];
    exp_base = int'(sec) * 512;
    for (int k = 0; k < 512; k++) sdat[k] = 8'bx;
    s_cnt = 0; s_order_err = 0; mr_cnt = 0; mr_err = 0; mw_cnt = 0; mw_err = 0;
    bh_cnt = 0; ack_rise = 0; ack_hi = 0; walk_cnt = 0; walk_bad = 0; r7_hi = 0;
    addr_prev = sd_buff_addr;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge sd_clk);
    #1;
  endtask

  task automatic wait_ack(input logic lvl, input string tag);
    int i;
    i = 0;
    while ((sd_ack !== lvl) && (i < 8000)) begin
      step(1);
      i++;
    end
    check_eq({tag, "_ack_wait"}, 32'(sd_ack), 32'(lvl));
  endtask

  task automatic run_xfer(input logic do_rd, input logic do_wr, input logic [31:0] lba,
                          input string tag);
    clear_mon(lba);
    sd_lba = lba;
    sd_rd  = do_rd;
    sd_wr  = do_wr;
    wait_ack(1'b1, tag);
    sd_rd = 1'b0;
    sd_wr = 1'b0;
    wait_ack(1'b0, tag);
    step(1);
  endtask

  // mode 0: byte k = k; mode 1: all 0x00; mode 2: byte k = k except byte 7 = 0xFF
  task automatic check_data(input string tag, input int mode);
    int bad;
    logic [7:0] e;
    bad = 0;
    for (int k = 0; k < 512; k++) begin
      e = (mode == 1) ? 8'h00 : ((mode == 2) && (k == 7)) ? 8'hFF : 8'(k);
      if (sdat[k] !== e) bad++;
    end
    check_eq({tag, "_data"}, 32'(bad), 32'd0);
    check_eq({tag, "_strobes"}, 32'(s_cnt), 32'd512);
    check_eq({tag, "_order"}, 32'(s_order_err), 32'd0);
  endtask

  initial begin
    reset = 1'b1; sd_lba = 32'd0; sd_rd = 1'b0; sd_wr = 1'b0; wp = 1'b0;
    lat_mode = 1'b0; nack_en = 1'b0;
    clear_mon(32'd0);
    step(3);
    check_eq("rst_flags", {26'd0, sd_ack, busy, err, mem_rd, mem_wr, sd_buff_wr}, 32'd0);
    check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_buff_addr", 32'(sd_buff_addr), 32'd0);
    reset = 1'b0;
    step(2);

    // Normal read, lba 0x123 -> image bytes 0x24600..0x247FF.
    run_xfer(1'b1, 1'b0, 32'h123, "rd");
    check_data("rd", 0);
    check_eq("rd_mem_cnt", 32'(mr_cnt), 32'd512);
    check_eq("rd_mem_addr", 32'(mr_err), 32'd0);
    check_eq("rd_err", 32'(err), 32'd0);
    check_eq("rd_ack_rise", 32'(ack_rise), 32'd1);
    check_eq("rd_ack_cycles", 32'(ack_hi), 32'd1024);

    // Normal write, lba 5 -> image bytes 0xA00..0xBFF get ~k.
    run_xfer(1'b0, 1'b1, 32'd5, "wr");
    check_eq("wr_mem_cnt", 32'(mw_cnt), 32'd512);
    check_eq("wr_mem_addr_data", 32'(mw_err), 32'd0);
    check_eq("wr_no_rd", 32'(mr_cnt), 32'd0);
    check_eq("wr_no_strobe", 32'(s_cnt), 32'd0);
    check_eq("wr_err", 32'(err), 32'd0);
    check_eq("wr_ack_cycles", 32'(ack_hi), 32'd2048);
    check_eq("wr_walk", 32'(walk_cnt), 32'd511);

    // Write protected: full walk, no memory writes, err set.
    wp = 1'b1;
    run_xfer(1'b0, 1'b1, 32'd5, "wp");
    wp = 1'b0;
    check_eq("wp_mem_cnt", 32'(mw_cnt), 32'd0);
    check_eq("wp_walk", 32'(walk_cnt), 32'd511);
    check_eq("wp_walk_step", 32'(walk_bad), 32'd0);
    check_eq("wp_err", 32'(err), 32'd1);
    check_eq("wp_ack_cycles", 32'(ack_hi), 32'd1536);

    // Following read with late-ack memory clears err.
    lat_mode = 1'b1;
    run_xfer(1'b1, 1'b0, 32'd0, "rdlat");
    lat_mode = 1'b0;
    check_data("rdlat", 0);
    check_eq("rdlat_err", 32'(err), 32'd0);
    check_eq("rdlat_mem_addr", 32'(mr_err), 32'd0);
    check_eq("rdlat_ack_cycles", 32'(ack_hi), 32'd1536);

    // Out of range: no memory access, zeros, err.
    run_xfer(1'b1, 1'b0, 32'h800, "oor");
    check_data("oor", 1);
    check_eq("oor_mem_cnt", 32'(mr_cnt), 32'd0);
    check_eq("oor_err", 32'(err), 32'd1);

    // Re-arm: rd held past sd_ack fall must not start a second transfer.
    clear_mon(32'h10);
    sd_lba = 32'h10;
    sd_rd  = 1'b1;
    wait_ack(1'b1, "rearm");
    wait_ack(1'b0, "rearm");
    step(3);
    check_eq("rearm_busy", 32'(busy), 32'd0);
    check_eq("rearm_one_xfer", 32'(ack_rise), 32'd1);
    sd_rd = 1'b0;
    step(1);
    run_xfer(1'b1, 1'b0, 32'h10, "rearm2");
    check_data("rearm2", 0);

    // rd and wr together: write first, read only after re-arm.
    clear_mon(32'd5);
    sd_lba = 32'd5;
    sd_rd  = 1'b1;
    sd_wr  = 1'b1;
    wait_ack(1'b1, "both");
    sd_wr = 1'b0;
    wait_ack(1'b0, "both");
    step(4);
    check_eq("both_wr_cnt", 32'(mw_cnt), 32'd512);
    check_eq("both_no_rd", 32'(mr_cnt), 32'd0);
    check_eq("both_idle", 32'(busy), 32'd0);
    check_eq("both_one_xfer", 32'(ack_rise), 32'd1);
    sd_rd = 1'b0;
    step(1);
    run_xfer(1'b1, 1'b0, 32'd5, "both_rd");
    check_data("both_rd", 0);
    check_eq("both_rd_cnt", 32'(mr_cnt), 32'd512);

    // Timeout on byte 7: 0xFF, err, transfer continues.
    nack_en = 1'b1;
    run_xfer(1'b1, 1'b0, 32'h40, "to");
    nack_en = 1'b0;
    check_data("to", 2);
    check_eq("to_err", 32'(err), 32'd1);
    check_eq("to_rd_cycles", 32'(r7_hi), 32'd1024);
    check_eq("to_mem_cnt", 32'(mr_cnt), 32'd511);
    check_eq("to_mem_addr", 32'(mr_err), 32'd0);

    // Reset in the middle of a read, then a clean transfer.
    begin
      int i;
      clear_mon(32'h20);
      sd_lba = 32'h20;
      sd_rd  = 1'b1;
      wait_ack(1'b1, "rstmid");
      sd_rd = 1'b0;
      i = 0;
      while ((s_cnt < 200) && (i < 2000)) begin
        step(1);
        i++;
      end
      check_eq("rstmid_reach", 32'(s_cnt >= 200), 32'd1);
      reset = 1'b1;
      step(1);
      check_eq("rstmid_flags", {28'd0, sd_ack, mem_rd, busy, sd_buff_wr}, 32'd0);
      reset = 1'b0;
      step(1);
    end
    run_xfer(1'b1, 1'b0, 32'h21, "post_rst");
    check_data("post_rst", 0);
    check_eq("post_rst_err", 32'(err), 32'd0);
    check_eq("never_both_req", 32'(bh_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
